// File: rtl/tty_writer.sv
// Glass-TTY writer: turns a byte stream into character-cell writes, scrolls and clears on the
// text display port, and mirrors the cursor into the controller. Define TTY_TAB_EN for tab stops.
module tty_writer #(
    parameter int COLS  = 128,
    parameter int ROWS  = 32,
    parameter int TAB_W = 8
) (
    input  logic        clk_data,
    input  logic        irst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic [6:0]  attr,
    output logic        busy,
    output logic [14:0] addrb,
    output logic [63:0] dinb,
    output logic [7:0]  web,
    output logic        enb,
    input  logic [63:0] doutb
);

    if (COLS % 4 != 0 || COLS < 4 || COLS > 128 || ROWS < 2 || ROWS > 64 ||
        TAB_W < 1 || (TAB_W & (TAB_W - 1)) != 0) begin : g_bad_params
        $error("tty_writer: illegal parameter set");
    end

    localparam logic [6:0] X_MAX       = 7'(COLS - 1);
    localparam logic [5:0] Y_MAX       = 6'(ROWS - 1);
    localparam logic [5:0] ROW_SCR_MAX = 6'(ROWS - 2);
    localparam logic [4:0] W_MAX       = 5'(COLS / 4 - 1);

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_DISPATCH, S_PUT, S_NEWLINE,
        S_SCR_RD, S_SCR_WR, S_CLRLAST, S_CLR, S_CURX, S_CURY
    } state_t;

    function automatic logic [63:0] blank_word(input logic [6:0] a);
        return {4{1'b0, a, 8'h20}};
    endfunction

    function automatic logic [14:0] word_addr(input logic [5:0] row, input logic [4:0] col);
        return {1'b0, row, col, 3'b000};
    endfunction

    state_t      state_r, state_s;
    logic [6:0]  x_r, x_s;
    logic [5:0]  y_r, y_s;
    logic [5:0]  row_r, row_s;
    logic [4:0]  col_r, col_s;
    logic [7:0]  chr_r, chr_s;
    logic [6:0]  attr_r, attr_s;

    logic [14:0] addr_s, addrb_r;
    logic [63:0] din_s, dinb_r;
    logic [7:0]  we_s, web_r;
    logic        en_s, enb_r;
    logic        rdy_s, rdy_r;
    logic        busy_s, busy_r;

`ifdef TTY_TAB_EN
    localparam logic [7:0] COLS_W   = 8'(COLS);
    localparam logic [7:0] TAB_MASK = ~(8'(TAB_W) - 8'd1);
    logic [7:0] tab_s;
    assign tab_s = ({1'b0, x_r} + 8'(TAB_W)) & TAB_MASK;
`endif

    // Next-state, cursor and scan-counter logic.
    always_comb begin
        state_s = state_r;
        x_s     = x_r;
        y_s     = y_r;
        row_s   = row_r;
        col_s   = col_r;
        chr_s   = chr_r;
        attr_s  = attr_r;
        case (state_r)
            S_INIT: state_s = S_CURX;
            S_IDLE: begin
                if (in_valid) begin
                    chr_s   = in_data;
                    attr_s  = attr;
                    state_s = S_DISPATCH;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_DISPATCH: begin
                if (chr_r >= 8'h20 && chr_r <= 8'h7E) begin
                    state_s = S_PUT;
                end else begin
                    case (chr_r)
                        8'h0D: begin
                            x_s     = 7'd0;
                            state_s = S_CURX;
                        end
                        8'h0A: state_s = S_NEWLINE;
                        8'h08: begin
                            if (x_r != 7'd0) begin
                                x_s = x_r - 7'd1;
                            end else begin
                                x_s = x_r;
                            end
                            state_s = S_CURX;
                        end
                        8'h0C: begin
                            x_s     = 7'd0;
                            y_s     = 6'd0;
                            row_s   = 6'd0;
                            col_s   = 5'd0;
                            state_s = S_CLR;
                        end
`ifdef TTY_TAB_EN
                        8'h09: begin
                            if (tab_s >= COLS_W) begin
                                x_s     = 7'd0;
                                state_s = S_NEWLINE;
                            end else begin
                                x_s     = tab_s[6:0];
                                state_s = S_CURX;
                            end
                        end
`endif
                        default: state_s = S_IDLE;
                    endcase
                end
            end
            S_PUT: begin
                if (x_r < X_MAX) begin
                    x_s     = x_r + 7'd1;
                    state_s = S_CURX;
                end else begin
                    x_s     = 7'd0;
                    state_s = S_NEWLINE;
                end
            end
            S_NEWLINE: begin
                if (y_r < Y_MAX) begin
                    y_s     = y_r + 6'd1;
                    state_s = S_CURX;
                end else begin
                    row_s   = 6'd0;
                    col_s   = 5'd0;
                    state_s = S_SCR_RD;
                end
            end
            S_SCR_RD: state_s = S_SCR_WR;
            S_SCR_WR: begin
                if (col_r == W_MAX) begin
                    col_s = 5'd0;
                    if (row_r == ROW_SCR_MAX) begin
                        state_s = S_CLRLAST;
                    end else begin
                        row_s   = row_r + 6'd1;
                        state_s = S_SCR_RD;
                    end
                end else begin
                    col_s   = col_r + 5'd1;
                    state_s = S_SCR_RD;
                end
            end
            S_CLRLAST: begin
                if (col_r == W_MAX) begin
                    col_s   = 5'd0;
                    state_s = S_CURX;
                end else begin
                    col_s = col_r + 5'd1;
                end
            end
            S_CLR: begin
                if (col_r == W_MAX) begin
                    col_s = 5'd0;
                    if (row_r == Y_MAX) begin
                        state_s = S_CURX;
                    end else begin
                        row_s = row_r + 6'd1;
                    end
                end else begin
                    col_s = col_r + 5'd1;
                end
            end
            S_CURX:  state_s = S_CURY;
            S_CURY:  state_s = S_IDLE;
            default: state_s = S_INIT;
        endcase
    end

    // Bus/handshake values for the upcoming cycle, decoded from the next state so they can be registered.
    always_comb begin
        addr_s = 15'd0;
        din_s  = 64'd0;
        we_s   = 8'd0;
        en_s   = 1'b0;
        rdy_s  = 1'b0;
        busy_s = 1'b1;
        case (state_s)
            S_IDLE: begin
                rdy_s  = 1'b1;
                busy_s = 1'b0;
            end
            S_PUT: begin
                en_s   = 1'b1;
                addr_s = word_addr(y_s, x_s[6:2]);
                din_s  = {48'd0, 1'b0, attr_s, chr_s} << {x_s[1:0], 4'd0};
                we_s   = 8'h03 << {x_s[1:0], 1'b0};
            end
            S_SCR_RD: begin
                en_s   = 1'b1;
                addr_s = word_addr(row_s + 6'd1, col_s);
            end
            S_SCR_WR: begin
                en_s   = 1'b1;
                we_s   = 8'hFF;
                addr_s = word_addr(row_s, col_s);
            end
            S_CLRLAST: begin
                en_s   = 1'b1;
                we_s   = 8'hFF;
                addr_s = word_addr(Y_MAX, col_s);
                din_s  = blank_word(attr_s);
            end
            S_CLR: begin
                en_s   = 1'b1;
                we_s   = 8'hFF;
                addr_s = word_addr(row_s, col_s);
                din_s  = blank_word(attr_s);
            end
            S_CURX: begin
                en_s   = 1'b1;
                we_s   = 8'hFF;
                addr_s = 15'h4010;
                din_s  = {57'd0, x_s};
            end
            S_CURY: begin
                en_s   = 1'b1;
                we_s   = 8'hFF;
                addr_s = 15'h4018;
                din_s  = {58'd0, y_s};
            end
            default: busy_s = 1'b1;
        endcase
    end

    // State, cursor and registered port outputs; reset aborts any operation in progress.
    always_ff @(posedge clk_data) begin
        if (irst) begin
            state_r <= S_INIT;
            x_r     <= 7'd0;
            y_r     <= 6'd0;
            row_r   <= 6'd0;
            col_r   <= 5'd0;
            chr_r   <= 8'd0;
            attr_r  <= 7'd0;
            addrb_r <= 15'd0;
            dinb_r  <= 64'd0;
            web_r   <= 8'd0;
            enb_r   <= 1'b0;
            rdy_r   <= 1'b0;
            busy_r  <= 1'b1;
        end else begin
            state_r <= state_s;
            x_r     <= x_s;
            y_r     <= y_s;
            row_r   <= row_s;
            col_r   <= col_s;
            chr_r   <= chr_s;
            attr_r  <= attr_s;
            addrb_r <= addr_s;
            dinb_r  <= din_s;
            web_r   <= we_s;
            enb_r   <= en_s;
            rdy_r   <= rdy_s;
            busy_r  <= busy_s;
        end
    end

    // Read data only arrives on the edge entering SCR_WR, so the copy write forwards it directly.
    assign dinb     = (state_r == S_SCR_WR) ? doutb : dinb_r;
    assign addrb    = addrb_r;
    assign web      = web_r;
    assign enb      = enb_r;
    assign in_ready = rdy_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_tty_writer.sv
// Self-checking bench for tty_writer: display RAM + cursor register model on the port,
// and a screen/cursor reference model driven by directed and random byte streams.
module tb_tty_writer;
    localparam int COLS  = 128;
    localparam int ROWS  = 32;
    localparam int TAB_W = 8;
    localparam int C4    = COLS / 4;
    localparam int SCROLL_EXTRA = 2 * (ROWS - 1) * C4 + C4;

    logic        clk_data = 1'b0;
    logic        irst     = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data  = 8'd0;
    logic [6:0]  attr     = 7'd0;
    logic        in_ready;
    logic        busy;
    logic [14:0] addrb;
    logic [63:0] dinb;
    logic [7:0]  web;
    logic        enb;
    logic [63:0] doutb = 64'd0;

    int checks   = 0;
    int failures = 0;

    always #5 clk_data = ~clk_data;

    tty_writer #(.COLS(COLS), .ROWS(ROWS), .TAB_W(TAB_W)) dut (
        .clk_data (clk_data),
        .irst     (irst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .attr     (attr),
        .busy     (busy),
        .addrb    (addrb),
        .dinb     (dinb),
        .web      (web),
        .enb      (enb),
        .doutb    (doutb)
    );

    // Display RAM and cursor registers as seen by the port
    logic [63:0] mem [0:2047];
    logic        mem_clr   = 1'b0;
    logic [6:0]  hw_x      = 7'h7F;
    logic [6:0]  hw_y      = 7'h7F;
    logic [14:0] last_addr = 15'h7FFF;
    logic [63:0] last_din  = 64'd0;
    logic [7:0]  last_we   = 8'd0;

    always @(posedge clk_data) begin
        if (mem_clr) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 64'd0;
        end else if (enb) begin
            if (web == 8'd0) begin
                doutb <= mem[addrb[13:3]];
            end else if (addrb[14]) begin
                if (addrb == 15'h4010) hw_x <= dinb[6:0];
                else if (addrb == 15'h4018) hw_y <= dinb[6:0];
            end else begin
                for (int b = 0; b < 8; b++)
                    if (web[b]) mem[addrb[13:3]][8*b +: 8] <= dinb[8*b +: 8];
                last_addr <= addrb;
                last_din  <= dinb;
                last_we   <= web;
            end
        end
    end

    // Reference screen: one 16-bit cell per character position plus cursor
    logic [15:0] scr [0:ROWS-1][0:COLS-1];
    int mx = 0;
    int my = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_newline(input logic [6:0] a, output int extra);
        if (my < ROWS - 1) begin
            my++;
            extra = 0;
        end else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
            for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = {1'b0, a, 8'h20};
            extra = SCROLL_EXTRA;
        end
    endtask

    // lat: cycles from handshake until in_ready is seen again; nen: enb cycles in between
    task automatic model_step(input logic [7:0] c, input logic [6:0] a, output int lat, output int nen);
        int extra;
        int t;
        extra = 0;
        t = 0;
        if (c >= 8'h20 && c <= 8'h7E) begin
            scr[my][mx] = {1'b0, a, c};
            if (mx < COLS - 1) begin
                mx++;
                lat = 5; nen = 3;
            end else begin
                mx = 0;
                model_newline(a, extra);
                lat = 6 + extra; nen = 3 + extra;
            end
        end else if (c == 8'h0D) begin
            mx = 0; lat = 4; nen = 2;
        end else if (c == 8'h08) begin
            if (mx > 0) mx--;
            lat = 4; nen = 2;
        end else if (c == 8'h0A) begin
            model_newline(a, extra);
            lat = 5 + extra; nen = 2 + extra;
        end else if (c == 8'h0C) begin
            for (int r = 0; r < ROWS; r++)
                for (int k = 0; k < COLS; k++) scr[r][k] = {1'b0, a, 8'h20};
            mx = 0; my = 0;
            lat = 4 + ROWS * C4; nen = 2 + ROWS * C4;
`ifdef TTY_TAB_EN
        end else if (c == 8'h09) begin
            t = (mx / TAB_W + 1) * TAB_W;
            if (t >= COLS) begin
                mx = 0;
                model_newline(a, extra);
                lat = 5 + extra; nen = 2 + extra;
            end else begin
                mx = t; lat = 4; nen = 2;
            end
`endif
        end else begin
            lat = 2; nen = 0;
        end
    endtask

    task automatic check_screen(input string tag);
        logic [63:0] o;
        logic [63:0] e;
        logic [63:0] ow;
        logic [63:0] ew;
        bit bad;
        o = 64'd0; e = 64'd0; bad = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int w = 0; w < C4; w++)
                if (!bad) begin
                    ew = {scr[r][4*w+3], scr[r][4*w+2], scr[r][4*w+1], scr[r][4*w]};
                    ow = mem[r * 32 + w];
                    o = ow; e = ew;
                    if (ow !== ew) bad = 1'b1;
                end
        check(tag, o, e);
    endtask

    task automatic send(input logic [7:0] c, input logic [6:0] a, output int lat, output int nen);
        bit done;
        @(negedge clk_data);
        in_valid = 1'b1; in_data = c; attr = a;
        @(posedge clk_data); #1;
        in_valid = 1'b0;
        lat = 0; nen = 0; done = 1'b0;
        for (int k = 1; k <= 6000 && !done; k++) begin
            if (k > 1) begin @(posedge clk_data); #1; end
            lat = k;
            if (in_ready) done = 1'b1;
            else if (enb) nen++;
        end
        if (!done) begin
            checks++; failures++;
            $error("FAIL ready_timeout observed=not_ready expected=ready byte=%0h", c);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "in_ready never returned");
        end
    endtask

    task automatic run_step(input logic [7:0] c, input logic [6:0] a, output int lat);
        int nen, el, en;
        send(c, a, lat, nen);
        model_step(c, a, el, en);
        check("latency", 64'(lat), 64'(el));
        check("enb_count", 64'(nen), 64'(en));
        check("xcursor", 64'(hw_x), 64'(mx));
        check("ycursor", 64'(hw_y), 64'(my));
        check_screen("screen");
    endtask

    task automatic hold_reset();
        irst = 1'b1; in_valid = 1'b0;
        repeat (3) @(posedge clk_data);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_enb", 64'(enb), 64'd0);
        check("rst_web", 64'(web), 64'd0);
        check("rst_addrb", 64'(addrb), 64'd0);
        check("rst_dinb", dinb, 64'd0);
    endtask

    task automatic release_reset();
        @(negedge clk_data);
        irst = 1'b0;
        @(posedge clk_data); #1;
        check("init_curx_addr", 64'(addrb), 64'h4010);
        check("init_curx_din", dinb, 64'd0);
        check("init_curx_enb", 64'(enb), 64'd1);
        check("init_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk_data); #1;
        check("init_cury_addr", 64'(addrb), 64'h4018);
        check("init_cury_din", dinb, 64'd0);
        @(posedge clk_data); #1;
        check("init_ready_4th", 64'(in_ready), 64'd1);
        mx = 0; my = 0;
    endtask

    initial begin
        int lat;
        int r;
        logic [7:0] c;
        for (int i = 0; i < ROWS; i++)
            for (int k = 0; k < COLS; k++) scr[i][k] = 16'd0;

        mem_clr = 1'b1;
        hold_reset();
        mem_clr = 1'b0;
        release_reset();

        // Two cells into word 0
        run_step(8'h41, 7'h0F, lat);
        check("A_addr", 64'(last_addr), 64'h0000);
        check("A_din", last_din, 64'h0F41);
        check("A_we", 64'(last_we), 64'h03);
        run_step(8'h42, 7'h0F, lat);
        check("B_addr", 64'(last_addr), 64'h0000);
        check("B_din", last_din, 64'h0F42_0000);
        check("B_we", 64'(last_we), 64'h0C);

        // CR, BS at column 0, BS after a char, ignored control byte
        run_step(8'h0D, 7'h01, lat);
        run_step(8'h08, 7'h01, lat);
        run_step(8'h43, 7'h25, lat);
        run_step(8'h08, 7'h25, lat);
        run_step(8'h07, 7'h25, lat);
        check("bel_latency", 64'(lat), 64'd2);

        // Full row with auto-wrap on the last column
        for (int i = 0; i < COLS; i++) run_step(8'h20 + 8'(i % 95), 7'(i), lat);
        check("wrap_addr", 64'(last_addr), 64'h00F8);
        check("wrap_we", 64'(last_we), 64'hC0);
        check("wrap_x", 64'(hw_x), 64'd0);
        check("wrap_y", 64'(hw_y), 64'd1);

        // Random pattern in row 1, walk down to the last row, then scroll
        for (int i = 0; i < COLS; i++) run_step(8'($urandom_range(32, 126)), 7'($urandom), lat);
        for (int i = 0; i < ROWS - 3; i++) run_step(8'h0A, 7'h12, lat);
        check("pre_scroll_y", 64'(hw_y), 64'(ROWS - 1));
        run_step(8'h0A, 7'h3A, lat);
        check("scroll_busy_cycles", 64'(lat - 1), 64'(2 * (ROWS - 1) * C4 + C4 + 4));
        check("scroll_y", 64'(hw_y), 64'(ROWS - 1));

        // Form feed with attr 0
        run_step(8'h0C, 7'h00, lat);
        check("ff_word0", mem[0], 64'h0020_0020_0020_0020);
        check("ff_lastword", mem[(ROWS - 1) * 32 + C4 - 1], 64'h0020_0020_0020_0020);

        // Reset in the middle of a clear
        @(negedge clk_data);
        in_valid = 1'b1; in_data = 8'h0C; attr = 7'h55;
        @(posedge clk_data); #1;
        in_valid = 1'b0;
        repeat (100) @(posedge clk_data);
        #1;
        check("midclr_enb", 64'(enb), 64'd1);
        @(negedge clk_data);
        irst = 1'b1;
        @(posedge clk_data); #1;
        check("abort_enb", 64'(enb), 64'd0);
        check("abort_busy", 64'(busy), 64'd1);
        release_reset();
        run_step(8'h0C, 7'h6B, lat);

        // Tab from column 3
        for (int i = 0; i < 3; i++) run_step(8'h78, 7'h07, lat);
        run_step(8'h09, 7'h07, lat);
`ifdef TTY_TAB_EN
        check("tab_x", 64'(hw_x), 64'd8);
`else
        check("tab_ignored_x", 64'(hw_x), 64'd3);
`endif

        // Random byte stream
        for (int i = 0; i < 250; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 80)      c = 8'($urandom_range(32, 126));
            else if (r < 86) c = 8'h0A;
            else if (r < 90) c = 8'h0D;
            else if (r < 94) c = 8'h08;
            else if (r < 95) c = 8'h0C;
            else if (r < 97) c = 8'h09;
            else             c = 8'($urandom_range(0, 255));
            run_step(c, 7'($urandom), lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
